// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester, clear-control and memory-pin bundle for mem_arbiter
interface mem_arbiter_if #(
  parameter int AW = 5,
  parameter int DW = 14
);
  logic          req0;
  logic          we0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] wdata0;
  logic          ack0;
  logic [DW-1:0] rdata0;

  logic          req1;
  logic          we1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata1;
  logic          ack1;
  logic [DW-1:0] rdata1;

  logic          clr_start;
  logic          busy;
  logic          clr_done;

  logic          mem_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout;

  // master: requesters plus the memory's read port
  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    output clr_start, mem_dout,
    input  ack0, rdata0, ack1, rdata1,
    input  busy, clr_done, mem_en, mem_addr, mem_din
  );

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    input  clr_start, mem_dout,
    output ack0, rdata0, ack1, rdata1,
    output busy, clr_done, mem_en, mem_addr, mem_din
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port round-robin req/ack arbiter with zero-fill clear sweep
module mem_arbiter #(
  parameter int AW    = 5,
  parameter int DW    = 14,
  parameter int DEPTH = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, ACK, CLEAR} state_t;

  state_t        state, state_nx;
  logic          rr;
  logic          sel;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [AW-1:0] cnt;
  logic [DW-1:0] rdata0_q;
  logic [DW-1:0] rdata1_q;
  logic          clr_done_q;

  logic          any_req;
  logic          gnt;
  logic          req_sel;
  logic          cnt_last;
  logic          mem_en_c;
  logic [AW-1:0] mem_addr_c;
  logic [DW-1:0] mem_din_c;

  always_comb begin
    any_req  = bus.req0 | bus.req1;
    gnt      = (bus.req0 && bus.req1) ? rr : bus.req1;
    req_sel  = sel ? bus.req1 : bus.req0;
    cnt_last = (cnt == AW'(DEPTH - 1));

    state_nx = state;
    case (state)
      IDLE: begin
        if (bus.clr_start)  state_nx = CLEAR;
        else if (any_req)   state_nx = ACCESS;
      end
      ACCESS:               state_nx = ACK;
      ACK:    if (!req_sel) state_nx = IDLE;
      CLEAR:  if (cnt_last) state_nx = IDLE;
      default:              state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      rr         <= 1'b0;
      sel        <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt        <= '0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
      clr_done_q <= 1'b0;
    end else begin
      state      <= state_nx;
      clr_done_q <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (!bus.clr_start && any_req) begin
            sel     <= gnt;
            we_q    <= gnt ? bus.we1    : bus.we0;
            addr_q  <= gnt ? bus.addr1  : bus.addr0;
            wdata_q <= gnt ? bus.wdata1 : bus.wdata0;
          end
        end
        ACCESS: begin
          rr <= ~sel;
          if (!we_q) begin
            if (sel) rdata1_q <= bus.mem_dout;
            else     rdata0_q <= bus.mem_dout;
          end
        end
        CLEAR: begin
          if (cnt_last) begin
            cnt        <= '0;
            clr_done_q <= 1'b1;
          end else begin
            cnt <= cnt + AW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Write strobe is gated by rst_n so a reset edge never lands a stray write.
  always_comb begin
    mem_en_c   = 1'b0;
    mem_addr_c = '0;
    mem_din_c  = '0;
    case (state)
      ACCESS: begin
        mem_en_c   = we_q & rst_n;
        mem_addr_c = addr_q;
        mem_din_c  = wdata_q;
      end
      CLEAR: begin
        mem_en_c   = rst_n;
        mem_addr_c = cnt;
      end
      default: ;
    endcase
  end

  assign bus.ack0     = (state == ACK) && !sel;
  assign bus.ack1     = (state == ACK) &&  sel;
  assign bus.rdata0   = rdata0_q;
  assign bus.rdata1   = rdata1_q;
  assign bus.busy     = (state != IDLE);
  assign bus.clr_done = clr_done_q;
  assign bus.mem_en   = mem_en_c;
  assign bus.mem_addr = mem_addr_c;
  assign bus.mem_din  = mem_din_c;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port round-robin arbiter and sequencer for the shared 32x14 data memory (sync write on clk when en=1, combinational read of the addressed word).
- Serves single-word read/write transactions from two requesters using a 4-phase req/ack handshake.
- Provides a memory clear sweep that writes zero to every address, with priority over requesters.
- Sits between the two requesters and the memory's clk/en/address/datain/dataout pins.

Parameters:
AW, 5, memory address width
DW, 14, memory data width
DEPTH, 32, number of words swept by clear; must equal 2**AW

Ports:
clk  in  1  system clock, all state updates on rising edge
rst_n  in  1  synchronous active-low reset
req0  in  1  requester 0 transaction request (level, 4-phase)
we0  in  1  requester 0: 1=write, 0=read; stable while req0=1
addr0  in  AW  requester 0 address; stable while req0=1
wdata0  in  DW  requester 0 write data; stable while req0=1
ack0  out  1  requester 0 acknowledge
rdata0  out  DW  requester 0 read data, valid while ack0=1 after a read
req1, we1, addr1, wdata1, ack1, rdata1: same as above for requester 1
clr_start  in  1  pulse: start zero-fill of all DEPTH words
busy  out  1  high in any state other than IDLE
clr_done  out  1  one-cycle pulse when the clear sweep completes
mem_en  out  1  to memory en (write strobe)
mem_addr  out  AW  to memory address
mem_din  out  DW  to memory datain
mem_dout  in  DW  from memory dataout (combinational read)

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - FSM goes to IDLE; rr pointer=0; clear counter=0.
  - ack0/ack1/clr_done/busy/mem_en=0; mem_addr=0; mem_din=0; rdata0/rdata1=0.
  - Memory contents are untouched. Reset mid-clear leaves the unswept addresses unchanged. Reset mid-transaction drops the transaction with no ack.
- FSM states: IDLE, ACCESS, ACK, CLEAR.
- IDLE:
  - If clr_start=1: go to CLEAR with cnt=0. clr_start has priority over requests.
  - Otherwise, if any req is high: grant per the rr pointer. If only one req is high, it wins. If both are high, the requester equal to the pointer wins.
  - On grant, latch sel, we, addr and wdata into internal registers, then go to ACCESS.
- ACCESS (exactly 1 cycle):
  - mem_addr=addr_q, mem_din=wdata_q, mem_en=we_q. The write lands at the edge ending ACCESS.
  - At that same edge, for a read, capture mem_dout into rdata_sel. For a write, rdata_sel holds its previous value.
  - Set the rr pointer to the non-selected requester, then go to ACK.
- ACK:
  - ack_sel=1, mem_en=0.
  - Stay while req_sel=1. When req_sel=0 is sampled, go to IDLE; ack drops that same edge.
  - The other requester's req waits. A new request from the same requester needs req low for at least one sampled cycle first.
- CLEAR:
  - mem_en=1, mem_addr=cnt, mem_din=0; cnt increments every cycle.
  - When cnt=DEPTH-1, go to IDLE with cnt=0 and pulse clr_done for the first IDLE cycle.
  - Duration is exactly DEPTH cycles. Requests asserted during CLEAR stay pending; clr_start is ignored outside IDLE.
- Latency: req sampled high at edge k (in IDLE) gives ACCESS in cycle k+1 and ack=1 from edge k+2. The minimum full handshake takes 4 cycles.
- mem_en is 1 only in ACCESS-with-write and in CLEAR, and never in IDLE or ACK.
- The ack outputs are mutually exclusive. At most one memory operation occurs per cycle.
- Widths: cnt is AW bits and wraps only via the explicit DEPTH-1 terminal check. No arithmetic is done on data.

Test Plan:
- Reset, then req0 write (addr 5, data 14'h1ABC) → mem_en=1 for exactly 1 cycle with addr 5 and din 1ABC; ack0 rises 2 cycles after req0 is sampled. Then req0 read addr 5 → rdata0=14'h1ABC while ack0=1.
- req0 and req1 both rise in the same cycle (reads of addrs 3 and 7) → req0 is granted first (pointer=0), then req1 after req0 drops. Repeat with both held → grants alternate 1, 0, 1.
- clr_start and req1 in the same IDLE cycle → 32 consecutive cycles of mem_en=1, addr 0..31, din 0, busy=1; clr_done pulses once. Then req1 is served, and a read of addr 5 returns 0.
- req0 held high for 6 cycles after ack0 → ack0 stays high and no second access occurs. After req0 drops, ack0 falls on the next edge and a pending req1 is then granted.
- rst_n=0 at cycle 10 of a clear sweep → busy=0 and no clr_done pulse; addrs 0..9 read 0 and addrs 10..31 keep their prior values. Reset during ACK → ack=0 the next cycle.
- clr_start pulsed while in ACK → ignored: no CLEAR, no clr_done.
